// File: rtl/mips_debug_ctrl.sv
// Purpose : host-byte-stream loader and run/step sequencer for the MIPS pipeline.
// Latency : program word written 1 cycle after its 4th byte; report bytes start 1 cycle after entering REPORT.
// Backpress: tx byte held stable while valid & ~ready; rx has no backpressure, bytes outside IDLE/LOAD are dropped.
//
// Ports:
//   i_clk, i_rst                 clock, async active-low reset
//   i_rx_data/i_rx_valid         host command/data bytes (one-cycle strobe)
//   o_tx_data/o_tx_valid/i_tx_ready  report bytes to host, valid/ready handshake
//   o_prog_we/o_prog_addr/o_prog_data  program memory write port
//   o_cpu_en                     pipeline enable (RUN and STEP only)
//   i_halt, i_pc                 CPU halt level and program counter
//   o_cycle_count                saturating count of enabled cycles
//   o_busy                       controller not in IDLE
module mips_debug_ctrl #(
    parameter int LEN               = 32,
    parameter int NB_ADDRESS        = 16,
    parameter int RAM_DEPTH_PROGRAM = 16,
    parameter int NB_BYTE           = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_prog_we,
    output logic [NB_ADDRESS-1:0] o_prog_addr,
    output logic [LEN-1:0]        o_prog_data,
    output logic                  o_cpu_en,
    input  logic                  i_halt,
    input  logic [LEN-1:0]        i_pc,
    output logic [LEN-1:0]        o_cycle_count,
    output logic                  o_busy
);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] BYTE_ERR = NB_BYTE'(8'hEE);
    localparam logic [NB_BYTE-1:0] MAX_LEN  = NB_BYTE'(RAM_DEPTH_PROGRAM);
    localparam int REP_BYTES = (2 * LEN) / NB_BYTE;
    localparam int REP_W     = $clog2(REP_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_LEN,
        ST_LOAD_DATA,
        ST_RUN,
        ST_STEP,
        ST_REPORT
    } state_t;

    state_t state, state_nxt;

    logic [NB_ADDRESS-1:0] load_len;
    logic [NB_ADDRESS-1:0] word_cnt;
    logic [1:0]            byte_cnt;
    logic [LEN-1:0]        asm_word;
    logic [2*LEN-1:0]      rep_shift;    // outgoing bytes, MSB byte is on the wire
    logic [REP_W-1:0]      rep_left;     // bytes still to hand off
    logic                  rep_armed;    // snapshot taken for this REPORT visit
    logic                  rep_single;   // one-byte ack/error report
    logic [NB_BYTE-1:0]    rep_byte;
    logic                  tx_vld;

    logic len_ok, last_byte, tx_fire, rep_done, load_done;

    assign len_ok    = (i_rx_data != '0) && (i_rx_data <= MAX_LEN);
    assign last_byte = (byte_cnt == 2'd3) && (word_cnt == load_len - NB_ADDRESS'(1));
    assign tx_fire   = tx_vld && i_tx_ready;
    assign rep_done  = rep_armed && tx_fire && (rep_left == REP_W'(1));
    assign load_done = (state == ST_LOAD_DATA) && i_rx_valid && last_byte;

    assign o_tx_valid = tx_vld;
    assign o_tx_data  = rep_shift[2*LEN-1 -: NB_BYTE];
    assign o_busy     = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_cpu_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_nxt = ST_LOAD_LEN;
                    end else if (i_rx_data == CMD_CONT) begin
                        state_nxt = i_halt ? ST_REPORT : ST_RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_nxt = i_halt ? ST_REPORT : ST_STEP;
                    end
                end
            end
            ST_LOAD_LEN: begin
                if (i_rx_valid) begin
                    state_nxt = len_ok ? ST_LOAD_DATA : ST_REPORT;
                end
            end
            ST_LOAD_DATA: begin
                if (load_done) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_RUN: begin
                // Halt gates the enable in the same cycle it is seen.
                o_cpu_en = ~i_halt;
                if (i_halt) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_STEP: begin
                o_cpu_en  = 1'b1;
                state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (rep_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            load_len      <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            asm_word      <= '0;
            rep_shift     <= '0;
            rep_left      <= '0;
            rep_armed     <= 1'b0;
            rep_single    <= 1'b0;
            rep_byte      <= '0;
            tx_vld        <= 1'b0;
            o_prog_we     <= 1'b0;
            o_prog_addr   <= '0;
            o_prog_data   <= '0;
            o_cycle_count <= '0;
        end else begin
            o_prog_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_CONT || i_rx_data == CMD_STEP)) begin
                        rep_single <= 1'b0;
                    end
                end
                ST_LOAD_LEN: begin
                    if (i_rx_valid) begin
                        if (len_ok) begin
                            load_len <= NB_ADDRESS'(i_rx_data);
                            word_cnt <= '0;
                            byte_cnt <= '0;
                        end else begin
                            rep_single <= 1'b1;
                            rep_byte   <= BYTE_ERR;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    if (i_rx_valid) begin
                        asm_word <= {asm_word[LEN-NB_BYTE-1:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            o_prog_we   <= 1'b1;
                            o_prog_addr <= word_cnt;
                            o_prog_data <= {asm_word[LEN-NB_BYTE-1:0], i_rx_data};
                            word_cnt    <= word_cnt + NB_ADDRESS'(1);
                        end
                        if (last_byte) begin
                            rep_single <= 1'b1;
                            rep_byte   <= CMD_LOAD;
                        end
                    end
                end
                ST_REPORT: begin
                    if (!rep_armed) begin
                        // CPU is stopped here, so i_pc and the counter are settled.
                        rep_armed <= 1'b1;
                        tx_vld    <= 1'b1;
                        if (rep_single) begin
                            rep_shift <= {rep_byte, {(2*LEN-NB_BYTE){1'b0}}};
                            rep_left  <= REP_W'(1);
                        end else begin
                            rep_shift <= {i_pc, o_cycle_count};
                            rep_left  <= REP_W'(REP_BYTES);
                        end
                    end else if (tx_fire) begin
                        rep_shift <= {rep_shift[2*LEN-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                        rep_left  <= rep_left - REP_W'(1);
                        if (rep_left == REP_W'(1)) begin
                            tx_vld    <= 1'b0;
                            rep_armed <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            if (load_done) begin
                o_cycle_count <= '0;
            end else if (o_cpu_en && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
module tb_mips_debug_ctrl;
    localparam int LEN = 32;
    localparam int NB_ADDRESS = 16;
    localparam int RAM_DEPTH_PROGRAM = 16;
    localparam int NB_BYTE = 8;

    logic                  clk;
    logic                  i_rst;
    logic [NB_BYTE-1:0]    i_rx_data;
    logic                  i_rx_valid;
    logic [NB_BYTE-1:0]    o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;
    logic                  o_prog_we;
    logic [NB_ADDRESS-1:0] o_prog_addr;
    logic [LEN-1:0]        o_prog_data;
    logic                  o_cpu_en;
    logic                  i_halt;
    logic [LEN-1:0]        i_pc;
    logic [LEN-1:0]        o_cycle_count;
    logic                  o_busy;

    mips_debug_ctrl #(
        .LEN(LEN), .NB_ADDRESS(NB_ADDRESS),
        .RAM_DEPTH_PROGRAM(RAM_DEPTH_PROGRAM), .NB_BYTE(NB_BYTE)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
        .o_cpu_en(o_cpu_en), .i_halt(i_halt), .i_pc(i_pc),
        .o_cycle_count(o_cycle_count), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations collected by the monitor; main block only reads them.
    logic [7:0]  got_q[$];
    logic [47:0] wr_q[$];
    int          en_cycles = 0;
    int          unstable = 0;
    logic        prev_vld = 1'b0;
    logic        prev_rdy = 1'b0;
    logic [7:0]  prev_dat = '0;

    // Reference model state.
    logic [7:0]  exp_q[$];
    logic [47:0] exp_wr[$];
    logic [31:0] model_count;
    int          got_rd = 0;
    int          wr_rd = 0;

    bit hold_low = 1'b0;
    bit rand_rdy = 1'b0;

    always @(negedge clk) begin
        if (i_rst) begin
            if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
            if (o_prog_we) wr_q.push_back({o_prog_addr, o_prog_data});
            if (o_cpu_en) en_cycles <= en_cycles + 1;
            if (prev_vld && !prev_rdy && (!o_tx_valid || o_tx_data !== prev_dat))
                unstable <= unstable + 1;
        end
        prev_vld <= o_tx_valid;
        prev_rdy <= i_tx_ready;
        prev_dat <= o_tx_data;
    end

    initial begin
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_tx_ready = hold_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    task automatic push_report(input logic [31:0] pc, input logic [31:0] cnt);
        for (int i = 3; i >= 0; i--) exp_q.push_back(pc[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) exp_q.push_back(cnt[i*8 +: 8]);
    endtask

    // Wait for the expected number of bytes and the return to IDLE, then compare.
    task automatic compare_tx(input string tag);
        int t;
        t = 0;
        while (((got_q.size() - got_rd) < exp_q.size() || o_busy) && t < 600) begin
            tick();
            t++;
        end
        check({tag, "_timeout"}, t < 600, 1);
        check({tag, "_ntx"}, got_q.size() - got_rd, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (got_rd + i < got_q.size())
                check({tag, "_tx"}, got_q[got_rd + i], exp_q[i]);
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wr_q.size() - wr_rd, exp_wr.size());
        for (int i = 0; i < exp_wr.size(); i++)
            if (wr_rd + i < wr_q.size())
                check({tag, "_wr"}, wr_q[wr_rd + i], exp_wr[i]);
        wr_rd = wr_q.size();
        exp_wr.delete();
    endtask

    task automatic do_load(input logic [31:0] words[$], input bit gaps, input string tag);
        int e0;
        int n;
        logic [31:0] w;
        logic [15:0] a;
        e0 = en_cycles;
        n = words.size();
        send_byte(8'h4C);
        send_byte(n[7:0]);
        for (int k = 0; k < n; k++) begin
            w = words[k];
            a = k[15:0];
            exp_wr.push_back({a, w});
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[b*8 +: 8]);
                if (gaps) repeat ($urandom_range(0, 2)) tick();
            end
        end
        exp_q.push_back(8'h4C);
        model_count = 32'd0;
        compare_tx(tag);
        check_writes(tag);
        check({tag, "_cpu_en"}, en_cycles - e0, 0);
        check({tag, "_count"}, o_cycle_count, model_count);
    endtask

    task automatic do_run(input int k, input logic [31:0] pc, input bit bp, input string tag);
        int e0, u0, g0, t;
        e0 = en_cycles;
        u0 = unstable;
        i_pc = pc;
        if (bp) hold_low = 1'b1;
        i_halt = (k == 0);
        send_byte(8'h43);
        for (int c = 0; c < k; c++) begin
            // A host byte during RUN must be dropped.
            if (c == 0) begin
                i_rx_data = 8'h4C;
                i_rx_valid = 1'b1;
            end
            tick();
            i_rx_valid = 1'b0;
        end
        i_halt = 1'b1;
        if (bp) begin
            t = 0;
            while (!o_tx_valid && t < 50) begin
                tick();
                t++;
            end
            check({tag, "_bp_vld_timeout"}, t < 50, 1);
            g0 = got_q.size();
            repeat (10) tick();
            check({tag, "_bp_held"}, got_q.size() - g0, 0);
            check({tag, "_bp_vld"}, o_tx_valid, 1);
            hold_low = 1'b0;
        end
        model_count = sat_add(model_count, k);
        push_report(pc, model_count);
        compare_tx(tag);
        check({tag, "_en"}, en_cycles - e0, k);
        check({tag, "_stable"}, unstable - u0, 0);
        check({tag, "_busy"}, o_busy, 0);
        i_halt = 1'b0;
    endtask

    task automatic do_step(input logic [31:0] pc, input bit halted, input string tag);
        int e0;
        e0 = en_cycles;
        i_pc = pc;
        i_halt = halted;
        send_byte(8'h53);
        model_count = sat_add(model_count, halted ? 0 : 1);
        push_report(pc, model_count);
        compare_tx(tag);
        check({tag, "_en"}, en_cycles - e0, halted ? 0 : 1);
        i_halt = 1'b0;
    endtask

    task automatic do_badlen(input logic [7:0] n, input string tag);
        send_byte(8'h4C);
        send_byte(n);
        exp_q.push_back(8'hEE);
        compare_tx(tag);
        check_writes(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, o_tx_data, 0);
        check({tag, "_tx_valid"}, o_tx_valid, 0);
        check({tag, "_prog_we"}, o_prog_we, 0);
        check({tag, "_prog_addr"}, o_prog_addr, 0);
        check({tag, "_prog_data"}, o_prog_data, 0);
        check({tag, "_cpu_en"}, o_cpu_en, 0);
        check({tag, "_count"}, o_cycle_count, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] w;
        logic [7:0]  junk;
        int op;

        i_rst = 1'b0;
        i_rx_data = '0;
        i_rx_valid = 1'b0;
        i_halt = 1'b0;
        i_pc = '0;
        model_count = 32'd0;

        #12;
        check_reset_outputs("reset");
        tick();
        i_rst = 1'b1;
        tick();

        // Directed two-word load.
        words = '{32'h1234_5678, 32'h9ABC_DEF0};
        do_load(words, 1'b0, "load2");

        // Continuous run: 5 enabled cycles, PC 0x14.
        do_run(5, 32'h14, 1'b0, "run5");

        // Clear the counter, then two single steps and a step while halted.
        words = '{32'h0000_0013};
        do_load(words, 1'b0, "load1");
        do_step(32'h4, 1'b0, "step1");
        do_step(32'h4, 1'b0, "step2");
        check("step2_count", o_cycle_count, 32'd2);
        do_step(32'h8, 1'b1, "step_halted");

        // Bad lengths, then a continuous command that halts immediately.
        do_badlen(8'h00, "badlen0");
        do_badlen(8'h11, "badlen17");
        do_run(0, 32'hDEAD_BEEF, 1'b0, "run_halted");

        // Report under transmitter backpressure.
        do_run(3, 32'h0000_0100, 1'b1, "run_bp");

        // Reset in the middle of a load: word 0 completes, word 1 is cut short.
        send_byte(8'h4C);
        send_byte(8'h02);
        w = 32'hCAFE_F00D;
        for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
        send_byte(8'h11);
        send_byte(8'h22);
        exp_wr.push_back({16'h0000, w});
        i_rst = 1'b0;
        #2;
        check_reset_outputs("midload_rst");
        tick();
        tick();
        i_rst = 1'b1;
        model_count = 32'd0;
        tick();
        check_writes("midload");
        got_rd = got_q.size();
        words = '{32'h0BAD_F00D};
        do_load(words, 1'b0, "reload");

        // Randomised mix of operations with a random transmitter ready.
        rand_rdy = 1'b1;
        for (int it = 0; it < 12; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    words.delete();
                    repeat ($urandom_range(1, RAM_DEPTH_PROGRAM)) words.push_back($urandom);
                    do_load(words, 1'b1, "rnd_load");
                end
                1: do_run($urandom_range(0, 15), $urandom, 1'b0, "rnd_run");
                2: do_step($urandom, 1'($urandom_range(0, 1)), "rnd_step");
                default: begin
                    junk = 8'($urandom);
                    if (junk == 8'h4C || junk == 8'h43 || junk == 8'h53) junk = 8'h00;
                    send_byte(junk);
                    check("rnd_junk_idle", o_busy, 0);
                    do_badlen(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)),
                              "rnd_badlen");
                end
            endcase
        end
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
